axim_wr_burst_ctrl: RTL
=======================

Name: axim_wr_burst_ctrl

Overview:
AXI4 write master controller directly downstream of mem_subsys. It takes a write job from the mem_subsys control interface (ctrl_waddr_offset/ctrl_wxfer_size/ctrl_wstart) and converts it into AXI4 INCR bursts on the AW/W/B channels. Store words arrive on the wr_tdata stream. ctrl_wdone pulses once every burst of the job has been acknowledged on B.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI and stream data width (bits)
C_XFER_SIZE_WIDTH, 32, width of the byte-count field
C_ADDR_BASE, 0, base address added to ctrl_waddr_offset_i
C_MAX_BURST_LEN, 16, max beats per burst (power of 2, ≤256)
C_MAX_OUTSTANDING, 4, max bursts issued on AW without a B response (power of 2)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-high
ctrl_waddr_offset_i  in  C_M_AXI_ADDR_WIDTH  job start byte offset
ctrl_wxfer_size_i  in  C_XFER_SIZE_WIDTH  job size in bytes (multiple of DATA_WIDTH/8)
ctrl_wstart_i  in  1  job start pulse
ctrl_wdone_o  out  1  one-cycle job-complete pulse
ctrl_werr_o  out  1  sticky: some bresp≠OKAY in the current or last job
wr_tdata_i  in  C_M_AXI_DATA_WIDTH  store word stream
wr_tvalid_i  in  1  stream valid
wr_tready_o  out  1  stream ready
m_axi_awvalid/awready  out/in  1  AW handshake
m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_wvalid/wready  out/in  1  W handshake
m_axi_wdata  out  C_M_AXI_DATA_WIDTH  write data
m_axi_wstrb  out  DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat of the burst
m_axi_bvalid/bready  in/out  1  B handshake
m_axi_bresp  in  2  write response

Behaviour:
- Reset (rstn=1): all outputs 0; FSM to IDLE; counters and the length FIFO cleared. Reset takes effect immediately, including mid-job. awsize/awburst/wstrb are the constant values given under Ports.
- Job accept: ctrl_wstart_i is sampled only in IDLE and ignored in any other state. Accept latches addr = (C_ADDR_BASE + offset) with the low log2(bytes) bits cleared, beats_left = size/bytes, and clears ctrl_werr_o.
- Zero-size job: ctrl_wdone_o pulses in the cycle after start; no AXI traffic.
- AW FSM states: IDLE -> CALC -> SEND -> (beats_left>0 ? CALC : WAIT_B) -> IDLE.
- CALC: len = min(beats_left, C_MAX_BURST_LEN, beats remaining to the next 4 KB boundary).
  - Stalls while outstanding == C_MAX_OUTSTANDING or the length FIFO is full.
  - On leaving CALC, pushes len into the FIFO.
- SEND: awvalid=1 and held stable until awready. On handshake: addr += len*bytes, beats_left -= len, outstanding += 1.
- W path:
  - Active when the FIFO is non-empty.
  - m_axi_wvalid = wr_tvalid_i & active; wr_tready_o = m_axi_wready & active; wdata = wr_tdata_i (combinational pass-through).
  - A beat counter asserts wlast on beat len-1. The wlast handshake pops the FIFO and resets the counter. The next burst's data may follow on the next cycle.
- B: bready=1 whenever outstanding>0. Each bvalid&bready decrements outstanding. bresp≠2'b00 sets ctrl_werr_o.
- An AW and a B handshake in the same cycle leave outstanding unchanged.
- WAIT_B -> IDLE once outstanding==0 and the FIFO is empty. ctrl_wdone_o=1 for exactly that transition cycle. A new start is accepted the following cycle.
- Width rules:
  - beats_left and counters are C_XFER_SIZE_WIDTH wide.
  - 4 KB remainder = (4096 - addr[11:0]) / bytes.
  - Address wrap past 2^ADDR_WIDTH is not detected and wraps modulo.

Decomposition:
- Package axim_pkg: AXI_BURST_INCR, AXI_RESP_OKAY, AXI_4K_BOUNDARY, aw_state_t enum (IDLE, CALC, SEND, WAIT_B).
- One sub-module: axim_len_fifo, a synchronous FIFO of 8-bit burst lengths with depth C_MAX_OUTSTANDING and full/empty flags.

Test Plan:
- Offset 0x40000000, size 4096, BASE=0, awready/wready/bvalid always asserted, tvalid=1 -> 64 bursts, each awlen=15, awaddr stepping by 0x40; 1024 W beats with data in order; exactly one wdone pulse.
- Offset 0x40000FF0, size 64 -> burst 1 awaddr 0x40000FF0, awlen=3; burst 2 awaddr 0x40001000, awlen=11; wlast on beats 4 and 16.
- Size 0 -> wdone pulse one cycle after start; awvalid never asserted.
- awready=1, bvalid held 0 for 200 cycles, size 1024 -> awvalid stops after exactly 4 handshakes. Releasing bvalid completes the job: 16 bursts, one wdone.
- bresp=2'b10 on burst 3 of 5 -> ctrl_werr_o rises after that B and stays high through wdone. The next start clears it.
- Random wready/tvalid, size 4096 -> W data matches the source sequence; wlast count = 64. Asserting rstn mid-burst zeros all outputs in the same cycle. A subsequent job completes correctly.

Source files
------------

// File: rtl/axim_pkg.sv
// Shared AXI4 encodings and the AW-side state type for the write burst controller.
// No logic; constants and types only.
// Imported by axim_wr_burst_ctrl and axim_len_fifo.
package axim_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam int         AXI_4K_BOUNDARY = 4096;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND,
    WAIT_B
  } aw_state_t;

endpackage

// File: rtl/axim_len_fifo.sv
// Synchronous FIFO holding the awlen (beats-1) of each burst queued for the W channel.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; the owner checks the flags.
module axim_len_fifo
  import axim_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axim_wr_burst_ctrl.sv
// AXI4 write master: splits a byte-count job into INCR bursts (max length, no 4 KB crossing) on AW/W/B.
// Latency: first AW two cycles after start; W data passes combinationally from the store stream.
// Backpressure: AW stalls at the outstanding-burst limit or full length queue; W follows wready/tvalid.
module axim_wr_burst_ctrl
  import axim_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            C_XFER_SIZE_WIDTH  = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_ADDR_BASE        = '0,
  parameter int                            C_MAX_BURST_LEN    = 16,
  parameter int                            C_MAX_OUTSTANDING  = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_waddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_wxfer_size_i,
  input  logic                              ctrl_wstart_i,
  output logic                              ctrl_wdone_o,
  output logic                              ctrl_werr_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_tdata_i,
  input  logic                              wr_tvalid_i,
  output logic                              wr_tready_o,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wlast,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  input  logic [1:0]                        m_axi_bresp
);

  localparam int AW       = C_M_AXI_ADDR_WIDTH;
  localparam int XW       = C_XFER_SIZE_WIDTH;
  localparam int BYTES    = C_M_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(BYTES - 1);

  aw_state_t     state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [XW-1:0] beats_left_q;
  logic [XW-1:0] burst_len_q;
  logic [XW-1:0] outstanding_q;
  logic [XW-1:0] beat_cnt_q;
  logic [7:0]    awlen_q;
  logic          werr_q;

  logic [XW-1:0] start_beats;
  logic [AW-1:0] start_addr;
  logic [12:0]   rem_bytes;
  logic [XW-1:0] rem_beats;
  logic [XW-1:0] calc_len;
  logic [7:0]    calc_awlen;
  logic          job_accept;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          out_full;
  logic          w_active;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;

  assign start_beats = ctrl_wxfer_size_i >> ADDR_LSB;
  assign start_addr  = (C_ADDR_BASE + ctrl_waddr_offset_i) & ADDR_MASK;
  assign rem_bytes   = 13'(AXI_4K_BOUNDARY) - {1'b0, addr_q[11:0]};
  assign rem_beats   = XW'(rem_bytes >> ADDR_LSB);
  assign calc_awlen  = 8'(calc_len - 1'b1);
  assign out_full    = (outstanding_q == XW'(C_MAX_OUTSTANDING));

  // Burst length: remaining job beats, clipped to the max burst and to the next 4 KB page.
  always_comb begin
    calc_len = beats_left_q;
    if (calc_len > XW'(C_MAX_BURST_LEN)) calc_len = XW'(C_MAX_BURST_LEN);
    if (calc_len > rem_beats)            calc_len = rem_beats;
  end

  // AW state register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // AW next state, job accept, length push, awvalid and the job-done pulse.
  always_comb begin
    state_d       = state_q;
    job_accept    = 1'b0;
    fifo_push     = 1'b0;
    ctrl_wdone_o  = 1'b0;
    m_axi_awvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_wstart_i) begin
          job_accept = 1'b1;
          state_d    = (start_beats == '0) ? WAIT_B : CALC;
        end
      end
      CALC: begin
        if (!out_full && !fifo_full) begin
          fifo_push = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = (beats_left_q == burst_len_q) ? WAIT_B : CALC;
      end
      WAIT_B: begin
        if (outstanding_q == '0 && fifo_empty) begin
          ctrl_wdone_o = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

  // Job address/beat bookkeeping, registered AW fields and the sticky error flag.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      addr_q       <= '0;
      beats_left_q <= '0;
      burst_len_q  <= '0;
      awlen_q      <= '0;
      werr_q       <= 1'b0;
    end else begin
      if (job_accept) begin
        addr_q       <= start_addr;
        beats_left_q <= start_beats;
        werr_q       <= 1'b0;
      end
      if (fifo_push) begin
        burst_len_q <= calc_len;
        awlen_q     <= calc_awlen;
      end
      if (aw_hs) begin
        addr_q       <= addr_q + (AW'(burst_len_q) << ADDR_LSB);
        beats_left_q <= beats_left_q - burst_len_q;
      end
      if (b_hs && m_axi_bresp != AXI_RESP_OKAY) werr_q <= 1'b1;
    end
  end

  // Bursts issued on AW and not yet answered on B; simultaneous AW and B cancel out.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      outstanding_q <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Beat position within the burst at the head of the length queue.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      beat_cnt_q <= '0;
    end else if (w_hs) begin
      beat_cnt_q <= m_axi_wlast ? '0 : beat_cnt_q + 1'b1;
    end
  end

  axim_len_fifo #(
    .DEPTH (C_MAX_OUTSTANDING),
    .WIDTH (8)
  ) u_len_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fifo_push),
    .push_dat (calc_awlen),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign w_active     = ~fifo_empty;
  assign fifo_pop     = w_hs & m_axi_wlast;
  assign m_axi_wvalid = wr_tvalid_i & w_active;
  assign wr_tready_o  = m_axi_wready & w_active;
  assign m_axi_wlast  = w_active & (beat_cnt_q == XW'(fifo_head));
  // Data is a straight pass-through, held at zero while reset is asserted.
  assign m_axi_wdata  = rstn ? '0 : wr_tdata_i;
  assign m_axi_wstrb  = '1;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(ADDR_LSB);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_bready  = (outstanding_q != '0);
  assign ctrl_werr_o   = werr_q;

endmodule
